comp_seq_nb: RTL and testbench

Parametrised, multi-cycle magnitude comparator: the successor to the fixed 16-bit combinational comparator. Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk, with a runtime unsigned/signed mode and valid/ready handshakes on both sides. It sits wherever a wide compare must not be a long combinational path, such as threshold checks and sorter/limit logic.

---
 rtl/comp_pkg.sv | 31 +++
 rtl/comp_seq_nb_if.sv | 35 +++
 rtl/comp_chunk.sv | 29 ++
 rtl/comp_seq_nb.sv | 148 ++++++++++++++
 tb/tb_comp_seq_nb.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/comp_pkg.sv
// Shared types and helpers for the multi-cycle magnitude comparator.
package comp_pkg;

    // Comparator FSM states
    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    // Result encoding {gt, lt, eq}; ResNone means no verdict yet
    typedef logic [2:0] res_t;
    localparam res_t ResNone = 3'b000;
    localparam res_t ResGt   = 3'b100;
    localparam res_t ResLt   = 3'b010;
    localparam res_t ResEq   = 3'b001;

    typedef struct packed {
        int unsigned nchunk;
        int unsigned cnt_w;
    } chunk_cfg_t;

    // Number of chunks and the width of a counter holding 0..nchunk
    function automatic chunk_cfg_t chunk_cfg(int unsigned width, int unsigned chunk);
        chunk_cfg_t cfg;
        cfg.nchunk = width / chunk;
        cfg.cnt_w  = $clog2(cfg.nchunk + 1);
        return cfg;
    endfunction

endpackage

// File: rtl/comp_seq_nb_if.sv
// Operand/result handshake bundle for comp_seq_nb.
interface comp_seq_nb_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
);
    import comp_pkg::*;

    localparam chunk_cfg_t Cfg = chunk_cfg(WIDTH, CHUNK);
    localparam int unsigned CntW = Cfg.cnt_w;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [CntW-1:0]  chunks;

    // Producer/consumer side
    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, gt, lt, eq, chunks
    );

    // Comparator side
    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, gt, lt, eq, chunks
    );

endinterface

// File: rtl/comp_chunk.sv
// Combinational CHUNK-bit unsigned compare with optional MSB inversion,
// which turns a two's-complement top chunk into an unsigned-orderable one.
module comp_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             msb_inv,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] flip;
    logic [CHUNK-1:0] xm;
    logic [CHUNK-1:0] ym;

    // Bias the sign bit, then compare as unsigned
    always_comb begin
        flip           = '0;
        flip[CHUNK-1]  = msb_inv;
        xm             = x ^ flip;
        ym             = y ^ flip;
        gt             = (xm > ym);
        lt             = (xm < ym);
        eq             = (xm == ym);
    end

endmodule

// File: rtl/comp_seq_nb.sv
// Multi-cycle magnitude comparator, MSB chunk first, CHUNK bits per cycle.
// Build option COMP_EARLY_EXIT_EN: when defined, SCAN stops at the first
// differing chunk; otherwise all chunks are scanned for constant latency.
module comp_seq_nb
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic          clk,
    input logic          rst_n,
    comp_seq_nb_if.slave bus
);

    localparam chunk_cfg_t Cfg = chunk_cfg(WIDTH, CHUNK);
    localparam int unsigned NChunk = Cfg.nchunk;
    localparam int unsigned CntW   = Cfg.cnt_w;
    localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(NChunk - 1);
    localparam logic [CntW-1:0] CntAll = CntW'(NChunk);

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("comp_seq_nb: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    res_t             res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [CHUNK-1:0] x_sel;
    logic [CHUNK-1:0] y_sel;
    logic             msb_inv;
    logic             c_gt, c_lt, c_eq;
    res_t             chunk_res;
    logic             done;

    // Select the chunk under inspection; sign handling only on the top chunk
    always_comb begin
        x_sel     = a_q[int'(idx_q) * CHUNK +: CHUNK];
        y_sel     = b_q[int'(idx_q) * CHUNK +: CHUNK];
        msb_inv   = sm_q && (idx_q == IdxTop);
        chunk_res = c_gt ? ResGt : (c_lt ? ResLt : ResEq);
    end

    comp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x       (x_sel),
        .y       (y_sel),
        .msb_inv (msb_inv),
        .gt      (c_gt),
        .lt      (c_lt),
        .eq      (c_eq)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sm_d    = bus.signed_mode;
                    idx_d   = IdxTop;
                    res_d   = ResNone;
                    cnt_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
`ifdef COMP_EARLY_EXIT_EN
                if (!c_eq) begin
                    res_d   = chunk_res;
                    cnt_d   = CntAll - CntW'(idx_q);
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    res_d   = ResEq;
                    cnt_d   = CntAll;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`else
                // Keep the first differing chunk's verdict; equal at the end means Eq
                if (res_q == ResNone && (!c_eq || idx_q == '0)) begin
                    res_d = chunk_res;
                end
                if (idx_q == '0) begin
                    cnt_d   = CntAll;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`endif
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            res_q   <= ResNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; results are zero unless DONE
    always_comb begin
        done          = (state_q == StDone);
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = done;
        bus.gt        = done && (res_q == ResGt);
        bus.lt        = done && (res_q == ResLt);
        bus.eq        = done && (res_q == ResEq);
        bus.chunks    = done ? cnt_q : '0;
    end

endmodule

// File: tb/tb_comp_seq_nb.sv
// Directed bench for comp_seq_nb at 16/4 and 32/8.
module tb_comp_seq_nb;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    comp_seq_nb_if #(.WIDTH(16), .CHUNK(4)) bus16 ();
    comp_seq_nb_if #(.WIDTH(32), .CHUNK(8)) bus32 ();

    comp_seq_nb #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    comp_seq_nb #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

`ifdef COMP_EARLY_EXIT_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    localparam logic [2:0] RGt = 3'b100;
    localparam logic [2:0] RLt = 3'b010;
    localparam logic [2:0] REq = 3'b001;
    localparam logic [2:0] RZ  = 3'b000;

    // Latency/chunk count for a verdict found at chunk k (4 chunks in both configs)
    function automatic int e(input int k);
        return Early ? k : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        chk("in_ready_idle16", {31'd0, bus16.in_ready}, 32'd1);
        bus16.a = a; bus16.b = b; bus16.signed_mode = sm; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.a = ~a; bus16.b = ~b; bus16.signed_mode = ~sm;
        chk("in_ready_busy16", {31'd0, bus16.in_ready}, 32'd0);
    endtask

    task automatic wait16(input string tag, input logic [2:0] res, input int lat, input int cnt);
        int k = 0;
        while (bus16.out_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_res"}, {29'd0, bus16.gt, bus16.lt, bus16.eq}, {29'd0, res});
        chk({tag, "_chunks"}, {29'd0, bus16.chunks}, cnt);
    endtask

    task automatic ack16();
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        chk("ack16_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("ack16_ready", {31'd0, bus16.in_ready}, 32'd1);
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input logic [2:0] res, input int lat, input int cnt);
        int k = 0;
        chk({tag, "_idle"}, {31'd0, bus32.in_ready}, 32'd1);
        bus32.a = a; bus32.b = b; bus32.signed_mode = sm; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        bus32.a = ~a; bus32.b = ~b; bus32.signed_mode = ~sm;
        while (bus32.out_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_res"}, {29'd0, bus32.gt, bus32.lt, bus32.eq}, {29'd0, res});
        chk({tag, "_chunks"}, {29'd0, bus32.chunks}, cnt);
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        chk({tag, "_ack"}, {31'd0, bus32.out_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        bus16.a = '0; bus16.b = '0; bus16.signed_mode = 1'b0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
        bus32.a = '0; bus32.b = '0; bus32.signed_mode = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus16.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("rst_res", {29'd0, bus16.gt, bus16.lt, bus16.eq}, {29'd0, RZ});
        chk("rst_chunks", {29'd0, bus16.chunks}, 32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Equal operands scan all chunks
        start16(16'h1234, 16'h1234, 1'b0); wait16("eq_1234", REq, 4, 4); ack16();
        // Top chunk decides
        start16(16'h8000, 16'h7FFF, 1'b0); wait16("u_8000", RGt, e(1), e(1)); ack16();
        start16(16'h8000, 16'h7FFF, 1'b1); wait16("s_8000", RLt, e(1), e(1)); ack16();
        // Bottom chunk decides
        start16(16'h1235, 16'h1234, 1'b0); wait16("gt_1235", RGt, 4, 4); ack16();
        // Third chunk decides
        start16(16'h1224, 16'h1234, 1'b0); wait16("lt_1224", RLt, e(3), e(3)); ack16();
        // Signed: sign bias only on the top chunk (-9 < -8)
        start16(16'hFFF7, 16'hFFF8, 1'b1); wait16("s_fff7", RLt, 4, 4); ack16();

        // Backpressure with a new request pending
        start16(16'h0001, 16'h0002, 1'b0); wait16("bp1", RLt, 4, 4);
        bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.signed_mode = 1'b0; bus16.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, bus16.out_valid}, 32'd1);
            chk("bp_res", {29'd0, bus16.gt, bus16.lt, bus16.eq}, {29'd0, RLt});
            chk("bp_chunks", {29'd0, bus16.chunks}, 32'd4);
            chk("bp_in_ready", {31'd0, bus16.in_ready}, 32'd0);
        end
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, bus16.in_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, bus16.out_valid}, 32'd0);
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        chk("bp_accepted", {31'd0, bus16.in_ready}, 32'd0);
        wait16("bp2", RGt, e(1), e(1)); ack16();

        // Reset mid-SCAN (idx=2)
        start16(16'h1234, 16'h1234, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("mid_rst_res", {29'd0, bus16.gt, bus16.lt, bus16.eq}, {29'd0, RZ});
        chk("mid_rst_chunks", {29'd0, bus16.chunks}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus16.in_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start16(16'hFFFF, 16'h0001, 1'b0); wait16("post_rst", RGt, e(1), e(1)); ack16();

        // Reset while holding a result in DONE
        start16(16'h8000, 16'h7FFF, 1'b0); wait16("pre_done_rst", RGt, e(1), e(1));
        rst_n = 1'b0;
        #1;
        chk("done_rst_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("done_rst_res", {29'd0, bus16.gt, bus16.lt, bus16.eq}, {29'd0, RZ});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 32-bit, 8-bit chunks
        run32("w32_s_ff", 32'hFFFFFFFF, 32'h00000001, 1'b1, RLt, e(1), e(1));
        run32("w32_u_ff", 32'hFFFFFFFF, 32'h00000001, 1'b0, RGt, e(1), e(1));
        run32("w32_s_min", 32'h80000000, 32'h7FFFFFFF, 1'b1, RLt, e(1), e(1));
        run32("w32_eq", 32'h12345678, 32'h12345678, 1'b1, REq, 4, 4);
        run32("w32_low", 32'h12345600, 32'h123456FF, 1'b1, RLt, 4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
